// File: rtl/ahb_slave_arbiter_if.sv
// AHB arbitration bundle: per-master requests and the muxed owner transfer
// information flow towards the arbiter; grant and address-phase ownership
// flow back to the masters and the address/control multiplexers.
interface ahb_slave_arbiter_if;
    logic [3:0] HBUSREQ;    // per-master bus request
    logic [3:0] HLOCK;      // per-master locked-transfer request
    logic [1:0] HTRANS;     // transfer type of the current address-phase owner
    logic [2:0] HBURST;     // burst type of the current address-phase owner
    logic       HREADY;     // shared slave ready
    logic [1:0] HRESP;      // shared slave response
    logic [3:0] HGRANT;     // one-hot grant
    logic [1:0] HMASTER;    // index of the address-phase owner
    logic       HMASTLOCK;  // current address phase is locked

    // Bus side: masters and slaves drive requests/transfer info, observe grants.
    modport master (
        output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
        input  HGRANT, HMASTER, HMASTLOCK
    );

    // Arbiter side.
    modport slave (
        input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
        output HGRANT, HMASTER, HMASTLOCK
    );
endinterface

// File: rtl/ahb_slave_arbiter.sv
// Round-robin AHB bus arbiter for up to four masters.
// A beat counter tracks fixed-length bursts so that ownership only changes on
// the final beat of a burst, on an idle owner, or after an error-type response
// has cut the burst short. Locked owners keep the bus until HLOCK drops.
module ahb_slave_arbiter #(
    parameter int NUMMASTERS = 4,
    parameter int DEFMASTER  = 0,
    parameter int TPD        = 1
) (
    input logic               HCLK,
    input logic               HRESETN,
    ahb_slave_arbiter_if.slave bus
);

    // Out-of-range parameters are folded back into the legal range.
    localparam int NM  = (NUMMASTERS < 2) ? 2 : ((NUMMASTERS > 4) ? 4 : NUMMASTERS);
    localparam int DEF = ((DEFMASTER >= 0) && (DEFMASTER < NM)) ? DEFMASTER : 0;

    localparam logic [1:0] DEF_IDX    = 2'(DEF);
    localparam logic [3:0] DEF_GRANT  = 4'(1 << DEF);
    localparam logic [3:0] VALID_MASK = 4'((1 << NM) - 1);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // TPD describes an output delay for behavioural simulation models only;
    // this implementation drives its registered outputs without delay.
    if (TPD < 0) begin : g_tpd_negative
    end

    // Remaining beats after the first one of a fixed-length burst.
    function automatic logic [4:0] burst_beats(input logic [2:0] burst);
        logic [4:0] beats;
        case (burst)
            3'b010, 3'b011: beats = 5'd3;   // WRAP4 / INCR4
            3'b100, 3'b101: beats = 5'd7;   // WRAP8 / INCR8
            3'b110, 3'b111: beats = 5'd15;  // WRAP16 / INCR16
            default:        beats = 5'd0;   // SINGLE / INCR
        endcase
        return beats;
    endfunction

    // Index of the asserted bit of a one-hot grant vector.
    function automatic logic [1:0] onehot_to_idx(input logic [3:0] onehot);
        logic [1:0] idx;
        case (onehot)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = DEF_IDX;
        endcase
        return idx;
    endfunction

    // Round-robin choice: scan upward from owner+1, wrapping modulo NM, so the
    // current owner is considered last. No request at all selects DEF.
    function automatic logic [3:0] rr_pick(input logic [3:0] req, input logic [1:0] owner);
        logic [3:0] pick;
        logic       found;
        logic [2:0] cand;
        pick  = DEF_GRANT;
        found = 1'b0;
        cand  = 3'd0;
        for (int k = 1; k <= NM; k++) begin
            cand = {1'b0, owner} + 3'(k);
            if (cand >= 3'(NM)) begin
                cand = cand - 3'(NM);
            end else begin
                cand = cand;
            end
            if (!found && req[cand[1:0]]) begin
                found = 1'b1;
                pick  = 4'b0001 << cand[1:0];
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    logic [3:0] grant_r;
    logic [1:0] master_r;
    logic       mastlock_r;
    logic [4:0] cnt_r;

    logic [3:0] req_s;
    logic       owner_locked_s;
    logic [1:0] grant_idx_s;
    logic [4:0] cnt_next_s;
    logic       arb_ok_s;
    logic [3:0] grant_next_s;

    assign req_s          = bus.HBUSREQ & VALID_MASK;
    assign owner_locked_s = bus.HLOCK[master_r];
    assign grant_idx_s    = onehot_to_idx(grant_r);

    // Beat count after the transfer presented this cycle. A stalled error-type
    // response abandons the burst so the following ready cycle may rearbitrate.
    always_comb begin
        cnt_next_s = cnt_r;
        if (bus.HREADY) begin
            case (bus.HTRANS)
                TRANS_NONSEQ: cnt_next_s = burst_beats(bus.HBURST);
                TRANS_SEQ: begin
                    if (cnt_r != 5'd0) begin
                        cnt_next_s = cnt_r - 5'd1;
                    end else begin
                        cnt_next_s = cnt_r;
                    end
                end
                TRANS_IDLE: begin
                    if (!owner_locked_s) begin
                        cnt_next_s = 5'd0;
                    end else begin
                        cnt_next_s = cnt_r;
                    end
                end
                TRANS_BUSY: cnt_next_s = cnt_r;
                default:    cnt_next_s = cnt_r;
            endcase
        end else begin
            if (bus.HRESP != RESP_OKAY) begin
                cnt_next_s = 5'd0;
            end else begin
                cnt_next_s = cnt_r;
            end
        end
    end

    // Arbitration is allowed when the accepted transfer leaves no beats
    // outstanding. Judging the post-transfer count means a SEQ that takes the
    // count from 1 to 0 releases the bus, while a NONSEQ opening a fixed-length
    // burst is not preempted on its first beat.
    always_comb begin
        arb_ok_s     = 1'b0;
        grant_next_s = grant_r;
        if (bus.HREADY && !owner_locked_s && (cnt_next_s == 5'd0)) begin
            arb_ok_s     = 1'b1;
            grant_next_s = rr_pick(req_s, master_r);
        end else begin
            arb_ok_s     = 1'b0;
            grant_next_s = grant_r;
        end
    end

    // Grant, ownership, lock and beat-count registers; ownership follows the
    // grant one accepted transfer later.
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            grant_r    <= DEF_GRANT;
            master_r   <= DEF_IDX;
            mastlock_r <= 1'b0;
            cnt_r      <= 5'd0;
        end else begin
            cnt_r   <= cnt_next_s;
            grant_r <= grant_next_s;
            if (bus.HREADY) begin
                master_r   <= grant_idx_s;
                mastlock_r <= bus.HLOCK[grant_idx_s];
            end else begin
                master_r   <= master_r;
                mastlock_r <= mastlock_r;
            end
        end
    end

    assign bus.HGRANT    = grant_r;
    assign bus.HMASTER   = master_r;
    assign bus.HMASTLOCK = mastlock_r;

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Self-checking bench for ahb_slave_arbiter: directed bus scenarios plus a
// randomized run, with a reference model feeding a scoreboard queue.
module tb_ahb_slave_arbiter;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    localparam logic [2:0] B_SINGLE = 3'b000;
    localparam logic [2:0] B_INCR4  = 3'b011;
    localparam logic [2:0] B_WRAP8  = 3'b100;
    localparam logic [2:0] B_INCR8  = 3'b101;

    localparam logic [1:0] R_OKAY  = 2'b00;
    localparam logic [1:0] R_ERROR = 2'b01;

    logic HCLK = 1'b0;
    logic HRESETN;

    ahb_slave_arbiter_if bus();

    ahb_slave_arbiter #(
        .NUMMASTERS(4),
        .DEFMASTER (0),
        .TPD       (1)
    ) dut (
        .HCLK   (HCLK),
        .HRESETN(HRESETN),
        .bus    (bus.slave)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [3:0] grant;
        logic [1:0] master;
        logic       lock;
    } exp_t;

    exp_t sb_q[$];

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model state.
    logic [3:0] m_grant;
    logic [1:0] m_master;
    logic       m_lock;
    logic [4:0] m_cnt;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_grant  = 4'b0001;
        m_master = 2'd0;
        m_lock   = 1'b0;
        m_cnt    = 5'd0;
    endtask

    // One clock edge of the arbiter as described by its requirements.
    task automatic model_step(input logic [3:0] req, input logic [3:0] lock,
                              input logic [1:0] tr, input logic [2:0] bu,
                              input logic rdy, input logic [1:0] rsp);
        logic [4:0] nc;
        logic [4:0] load;
        logic [1:0] g_idx;
        logic [1:0] j;
        logic       ok;
        logic [3:0] ng;
        g_idx = 2'd0;
        for (int b = 0; b < 4; b++) if (m_grant[b]) g_idx = 2'(b);
        case (bu[2:1])
            2'b01:   load = 5'd3;
            2'b10:   load = 5'd7;
            2'b11:   load = 5'd15;
            default: load = 5'd0;
        endcase
        nc = m_cnt;
        if (!rdy) begin
            if (rsp != R_OKAY) nc = 5'd0;
        end else if (tr == T_NONSEQ) begin
            nc = load;
        end else if (tr == T_SEQ) begin
            if (m_cnt > 5'd0) nc = m_cnt - 5'd1;
        end else if (tr == T_IDLE) begin
            if (!lock[m_master]) nc = 5'd0;
        end
        ok = rdy && !lock[m_master] && (nc == 5'd0);
        ng = m_grant;
        if (ok) begin
            ng = 4'b0001;
            for (int k = 4; k >= 1; k--) begin
                j = m_master + 2'(k);
                if (req[j]) ng = 4'b0001 << j;
            end
        end
        if (rdy) begin
            m_lock   = lock[g_idx];
            m_master = g_idx;
        end
        m_grant = ng;
        m_cnt   = nc;
    endtask

    // Drive one cycle at the falling edge, predict, check after the rising edge.
    task automatic step(input logic [3:0] req, input logic [3:0] lock,
                        input logic [1:0] tr, input logic [2:0] bu,
                        input logic rdy, input logic [1:0] rsp);
        exp_t e;
        bus.HBUSREQ = req;
        bus.HLOCK   = lock;
        bus.HTRANS  = tr;
        bus.HBURST  = bu;
        bus.HREADY  = rdy;
        bus.HRESP   = rsp;
        model_step(req, lock, tr, bu, rdy, rsp);
        e.grant  = m_grant;
        e.master = m_master;
        e.lock   = m_lock;
        sb_q.push_back(e);
        @(posedge HCLK);
        #1;
        e = sb_q.pop_front();
        check_eq("sb_grant", {28'd0, bus.HGRANT}, {28'd0, e.grant});
        check_eq("sb_master", {30'd0, bus.HMASTER}, {30'd0, e.master});
        check_eq("sb_mastlock", {31'd0, bus.HMASTLOCK}, {31'd0, e.lock});
        @(negedge HCLK);
    endtask

    task automatic drive_idle();
        bus.HBUSREQ = 4'b0000;
        bus.HLOCK   = 4'b0000;
        bus.HTRANS  = T_IDLE;
        bus.HBURST  = B_SINGLE;
        bus.HREADY  = 1'b1;
        bus.HRESP   = R_OKAY;
    endtask

    // Asynchronous reset pulse between clock edges; outputs must restore at once.
    task automatic pulse_reset();
        #2;
        HRESETN = 1'b0;
        #1;
        model_reset();
        check_eq("rst_grant", {28'd0, bus.HGRANT}, 32'h1);
        check_eq("rst_master", {30'd0, bus.HMASTER}, 32'h0);
        check_eq("rst_mastlock", {31'd0, bus.HMASTLOCK}, 32'h0);
        drive_idle();
        @(negedge HCLK);
        HRESETN = 1'b1;
    endtask

    // Owner M1 granted with M2 also requesting (from reset state).
    task automatic setup_m1_owner();
        step(4'b0010, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OKAY);
        step(4'b0110, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OKAY);
        check_eq("setup_grant", {28'd0, bus.HGRANT}, 32'h2);
        check_eq("setup_master", {30'd0, bus.HMASTER}, 32'h1);
    endtask

    // Bound on total run time.
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        HRESETN = 1'b0;
        drive_idle();
        model_reset();
        repeat (2) @(negedge HCLK);
        check_eq("por_grant", {28'd0, bus.HGRANT}, 32'h1);
        check_eq("por_master", {30'd0, bus.HMASTER}, 32'h0);
        check_eq("por_mastlock", {31'd0, bus.HMASTLOCK}, 32'h0);
        HRESETN = 1'b1;

        // Idle bus stays with the default master.
        repeat (4) step(4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OKAY);
        check_eq("idle_grant", {28'd0, bus.HGRANT}, 32'h1);
        check_eq("idle_master", {30'd0, bus.HMASTER}, 32'h0);

        // M1 and M2 alternate on SINGLE transfers.
        for (int i = 0; i < 3; i++)
            step(4'b0110, 4'b0000, (m_master == 2'd0) ? T_IDLE : T_NONSEQ, B_SINGLE, 1'b1, R_OKAY);
        check_eq("rr_grant_m2", {28'd0, bus.HGRANT}, 32'h4);
        check_eq("rr_master_m1", {30'd0, bus.HMASTER}, 32'h1);
        for (int i = 0; i < 2; i++)
            step(4'b0110, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1, R_OKAY);
        check_eq("rr_grant_m1", {28'd0, bus.HGRANT}, 32'h2);
        check_eq("rr_master_m2", {30'd0, bus.HMASTER}, 32'h2);
        for (int i = 0; i < 3; i++)
            step(4'b0110, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1, R_OKAY);

        // INCR8 by M1 holds the grant until the eighth beat.
        pulse_reset();
        setup_m1_owner();
        step(4'b0110, 4'b0000, T_NONSEQ, B_INCR8, 1'b1, R_OKAY);
        check_eq("incr8_beat1", {28'd0, bus.HGRANT}, 32'h2);
        for (int i = 0; i < 6; i++) begin
            step(4'b0110, 4'b0000, T_SEQ, B_INCR8, 1'b1, R_OKAY);
            check_eq("incr8_hold", {28'd0, bus.HGRANT}, 32'h2);
        end
        step(4'b0110, 4'b0000, T_SEQ, B_INCR8, 1'b1, R_OKAY);
        check_eq("incr8_beat8", {28'd0, bus.HGRANT}, 32'h4);

        // INCR4 with a wait-state stall and a BUSY cycle.
        pulse_reset();
        setup_m1_owner();
        step(4'b0110, 4'b0000, T_NONSEQ, B_INCR4, 1'b1, R_OKAY);
        step(4'b0110, 4'b0000, T_SEQ, B_INCR4, 1'b1, R_OKAY);
        for (int i = 0; i < 3; i++) begin
            step(4'b0110, 4'b0000, T_SEQ, B_INCR4, 1'b0, R_OKAY);
            check_eq("stall_grant", {28'd0, bus.HGRANT}, 32'h2);
            check_eq("stall_master", {30'd0, bus.HMASTER}, 32'h1);
        end
        step(4'b0110, 4'b0000, T_BUSY, B_INCR4, 1'b1, R_OKAY);
        check_eq("busy_grant", {28'd0, bus.HGRANT}, 32'h2);
        step(4'b0110, 4'b0000, T_SEQ, B_INCR4, 1'b1, R_OKAY);
        check_eq("incr4_beat3", {28'd0, bus.HGRANT}, 32'h2);
        step(4'b0110, 4'b0000, T_SEQ, B_INCR4, 1'b1, R_OKAY);
        check_eq("incr4_beat4", {28'd0, bus.HGRANT}, 32'h4);

        // Locked M3 keeps the bus while M0 waits.
        pulse_reset();
        step(4'b1000, 4'b1000, T_IDLE, B_SINGLE, 1'b1, R_OKAY);
        check_eq("lock_grant_m3", {28'd0, bus.HGRANT}, 32'h8);
        step(4'b1001, 4'b1000, T_IDLE, B_SINGLE, 1'b1, R_OKAY);
        check_eq("lock_phase1", {31'd0, bus.HMASTLOCK}, 32'h1);
        check_eq("lock_master", {30'd0, bus.HMASTER}, 32'h3);
        step(4'b1001, 4'b1000, T_NONSEQ, B_SINGLE, 1'b1, R_OKAY);
        check_eq("lock_phase2", {31'd0, bus.HMASTLOCK}, 32'h1);
        check_eq("lock_hold", {28'd0, bus.HGRANT}, 32'h8);
        step(4'b0001, 4'b1000, T_NONSEQ, B_SINGLE, 1'b1, R_OKAY);
        check_eq("lock_noreq_hold", {28'd0, bus.HGRANT}, 32'h8);
        step(4'b0001, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OKAY);
        check_eq("unlock_grant_m0", {28'd0, bus.HGRANT}, 32'h1);
        check_eq("unlock_mastlock", {31'd0, bus.HMASTLOCK}, 32'h0);

        // ERROR response on beat 2 of WRAP8 ends the burst.
        pulse_reset();
        setup_m1_owner();
        step(4'b0110, 4'b0000, T_NONSEQ, B_WRAP8, 1'b1, R_OKAY);
        step(4'b0110, 4'b0000, T_SEQ, B_WRAP8, 1'b1, R_OKAY);
        step(4'b0110, 4'b0000, T_SEQ, B_WRAP8, 1'b0, R_ERROR);
        check_eq("err_stall_grant", {28'd0, bus.HGRANT}, 32'h2);
        step(4'b0110, 4'b0000, T_BUSY, B_WRAP8, 1'b1, R_ERROR);
        check_eq("err_rearb_grant", {28'd0, bus.HGRANT}, 32'h4);

        // Reset in the middle of a burst discards it.
        pulse_reset();
        setup_m1_owner();
        step(4'b0110, 4'b0000, T_NONSEQ, B_WRAP8, 1'b1, R_OKAY);
        step(4'b0110, 4'b0000, T_SEQ, B_WRAP8, 1'b1, R_OKAY);
        step(4'b0110, 4'b0000, T_SEQ, B_WRAP8, 1'b1, R_OKAY);
        pulse_reset();
        step(4'b0100, 4'b0000, T_BUSY, B_SINGLE, 1'b1, R_OKAY);
        check_eq("post_rst_grant", {28'd0, bus.HGRANT}, 32'h4);

        // Randomized traffic checked against the model.
        pulse_reset();
        for (int i = 0; i < 400; i++) begin
            step(4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
                 2'($urandom_range(0, 3)),
                 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : R_OKAY);
        end

        check_eq("sb_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/ahb_slave_arbiter.md
AHB_SLAVE_ARBITER -- requirements
Module: ahb_slave_arbiter

Interface
REQ-001 SHALL have parameter NUMMASTERS, default 4, number of active masters (legal 2..4); request inputs above NUMMASTERS-1 are ignored.
REQ-002 SHALL have parameter DEFMASTER, default 0, the master granted when no request is pending.
REQ-003 SHALL have parameter TPD, default 1, the output delay in ns applied to registered outputs (simulation only).
REQ-004 SHALL have port HCLK, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-005 SHALL have port HRESETN, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port HBUSREQ, input, 4 bits: per-master bus request.
REQ-007 SHALL have port HLOCK, input, 4 bits: per-master locked-transfer request.
REQ-008 SHALL have port HTRANS, input, 2 bits: muxed transfer type of the current owner.
REQ-009 SHALL have port HBURST, input, 3 bits: muxed burst type of the current owner.
REQ-010 SHALL have port HREADY, input, 1 bit: shared slave-ready signal.
REQ-011 SHALL have port HRESP, input, 2 bits: shared slave response.
REQ-012 SHALL have port HGRANT, output, 4 bits: one-hot grant.
REQ-013 SHALL have port HMASTER, output, 2 bits: index of the master owning the address phase.
REQ-014 SHALL have port HMASTLOCK, output, 1 bit: current address phase is locked.

Function
REQ-015 SHALL keep a beat counter CNT (5 bits): on an accepted NONSEQ (HREADY=1), load 3/7/15 for INCR4|WRAP4, INCR8|WRAP8 and INCR16|WRAP16, and 0 for SINGLE|INCR.
REQ-016 SHALL decrement CNT on each accepted SEQ with CNT>0; BUSY and IDLE SHALL leave CNT unchanged.
REQ-017 SHALL assert internal ARB_OK when all of the following hold: HREADY=1, CNT is 0 (or is 1 with an accepted SEQ this cycle), and HLOCK[HMASTER]=0.
REQ-018 SHALL treat HTRANS=IDLE with HREADY=1 from an unlocked owner as ARB_OK regardless of CNT, and SHALL clear CNT to 0 in that case.
REQ-019 SHALL, when ARB_OK, select the next owner round-robin: search HBUSREQ from HMASTER+1 upward, wrapping modulo NUMMASTERS; the current owner is lowest priority.
REQ-020 SHALL select DEFMASTER when ARB_OK and no request is pending.
REQ-021 SHALL register the selection into HGRANT on the same HCLK edge, giving a latency of 1 cycle from request to grant.
REQ-022 SHALL keep HGRANT unchanged whenever ARB_OK=0.
REQ-023 SHALL load HMASTER with the index of HGRANT on every edge where HREADY=1; HMASTER therefore lags HGRANT by one accepted transfer.
REQ-024 SHALL load HMASTLOCK with HLOCK[granted index] on every edge where HREADY=1.
REQ-025 SHALL hold HMASTER, HMASTLOCK and CNT while HREADY=0, whatever happens on HBUSREQ.
REQ-026 SHALL, on HRESP=ERROR|RETRY|SPLIT seen with HREADY=0, clear CNT to 0 on that edge so that the next HREADY=1 permits rearbitration.
REQ-027 SHALL keep a locked owner that drops HBUSREQ granted until HLOCK deasserts and ARB_OK.
REQ-028 SHALL resolve simultaneous requests by REQ-019 only; a request asserted in the same cycle as ARB_OK SHALL be considered.

Reset
REQ-029 SHALL, when HRESETN=0, asynchronously set HGRANT to one-hot DEFMASTER, HMASTER to DEFMASTER, HMASTLOCK to 0 and CNT to 0.
REQ-030 SHALL resume arbitration on the first HCLK edge after HRESETN deasserts; any burst in flight at reset is discarded.

Verification
REQ-031 Idle bus, HBUSREQ=0000 -> HGRANT=0001 and HMASTER=0 permanently.
REQ-032 HBUSREQ=0110 held, all SINGLE NONSEQ transfers, HREADY=1 -> grants alternate 0010,0100,0010...; HMASTER follows one cycle later.
REQ-033 M1 performs an INCR8 while M2 requests -> HGRANT stays 0010 for 8 accepted beats; it switches to 0100 on the edge accepting beat 8.
REQ-034 INCR4 with HREADY=0 for 3 cycles mid-burst and a BUSY inserted -> CNT unchanged during the stall and BUSY; grant held until beat 4.
REQ-035 M3 asserts HLOCK with 2 SINGLE transfers while M0 requests -> HMASTLOCK=1 for both address phases; M0 granted only after HLOCK=0.
REQ-036 ERROR response on beat 2 of WRAP8, HRESETN pulsed low mid-burst -> rearbitration on the next HREADY=1 after the error; reset immediately restores HGRANT=0001, HMASTER=0.
